// File: rtl/mem_pkg.sv
// Shared memory-hierarchy constants and small elaboration helpers.
package mem_pkg;

    localparam int WORD_WIDTH     = 16;
    localparam int RAM8_ADDR_BITS = 3;
    localparam int RAM8_DEPTH     = 8;

    // Tree depth of node k in a heap-indexed binary tree (root = 0).
    function automatic int tree_level(input int k);
        return $clog2(k + 2) - 1;
    endfunction

endpackage

// File: rtl/ram8_reg_word.sv
// One storage word: load-enabled register with asynchronous clear.
module reg_word
    import mem_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Next value: take new data when enabled, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (load) word_d = in;
    end

    // Word register; reset clears it immediately, without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_q <= '0;
        else       word_q <= word_d;
    end

    assign out = word_q;

endmodule

// File: rtl/ram8.sv
// Eight-word register file: DMux tree fans load out to one word, Mux reads back.
module ram8
    import mem_pkg::*;
#(
    parameter int WIDTH     = WORD_WIDTH,
    parameter int ADDR_BITS = RAM8_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] address,
    output logic [WIDTH-1:0]     out
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Heap-indexed demux tree: node 0 is load, node k splits into 2k+1 (bit=0)
    // and 2k+2 (bit=1). Address is consumed MSB first, so leaf DEPTH-1+i is word i.
    logic [2*DEPTH-2:0]          node;
    logic [DEPTH-1:0]            we;
    logic [DEPTH-1:0][WIDTH-1:0] word;

    assign node[0] = load;

    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_dmux
        localparam int LVL = tree_level(k);
        logic sel;
        assign sel          = address[ADDR_BITS-1-LVL];
        assign node[2*k+1]  = node[k] & ~sel;
        assign node[2*k+2]  = node[k] &  sel;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign we[i] = node[DEPTH-1+i];

        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .in    (in),
            .load  (we[i]),
            .out   (word[i])
        );
    end

    // Read mux: purely from stored words, no path from in/load.
    assign out = word[address];

endmodule

// File: tb/tb_ram8.sv
// Randomized + directed bench for ram8 with a queue-based scoreboard.
module tb_ram8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        load;
    logic [2:0]  address;
    logic [15:0] dout;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [8];

    typedef struct {
        string       nm;
        logic [2:0]  a;
        logic [15:0] exp;
    } item_t;

    item_t sb [$];
    event  chk_ev;

    ram8 dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .load    (load),
        .address (address),
        .out     (dout)
    );

    always #5 clk = ~clk;

    // Monitor: whenever a read is presented, pop expectations and compare.
    initial begin
        item_t it;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                checks++;
                if (dout !== it.exp) begin
                    failures++;
                    $display("FAIL %s addr=%0d got=%h want=%h", it.nm, it.a, dout, it.exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [2:0] a, input logic [15:0] e);
        item_t it;
        address = a;
        #1;
        it.nm = nm; it.a = a; it.exp = e;
        sb.push_back(it);
        ->chk_ev;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; din = d; load = 1'b1;
        @(posedge clk);
        if (!reset) model[a] = d;
        #1;
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; din = '0; address = '0;
        clear_model();

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) chk("reset_init", 3'(i), 16'h0);
        @(negedge clk) reset = 1'b0;

        // Write/read sweep.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) chk("sweep", 3'(i), 16'h1000 + 16'(i));

        // No write-through bypass.
        @(negedge clk);
        address = 3'd3; din = 16'hBEEF; load = 1'b1;
        chk("nobypass_pre", 3'd3, 16'h1003);
        @(posedge clk);
        #1 load = 1'b0;
        model[3] = 16'hBEEF;
        chk("nobypass_post", 3'd3, 16'hBEEF);

        // Isolation.
        do_write(3'd5, 16'hFFFF);
        for (int i = 0; i < 8; i++)
            chk("isolation", 3'(i), (i == 5) ? 16'hFFFF :
                                   (i == 3) ? 16'hBEEF : 16'h1000 + 16'(i));

        // Reset wins over a concurrent write.
        @(negedge clk);
        reset = 1'b1; load = 1'b1; address = 3'd2; din = 16'h1234;
        chk("rstpri_async", 3'd2, 16'h0);
        @(posedge clk);
        #1 load = 1'b0;
        clear_model();
        for (int i = 0; i < 8; i++) chk("rstpri_all", 3'(i), 16'h0);
        @(negedge clk) reset = 1'b0;
        chk("rstpri_release", 3'd2, 16'h0);
        @(posedge clk);
        #1 chk("rstpri_after_edge", 3'd2, 16'h0);

        // Reset in the middle of operation.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'($urandom_range(1, 16'hFFFF)));
        @(negedge clk) reset = 1'b1;
        chk("rstmid_immediate", 3'd4, 16'h0);
        clear_model();
        for (int i = 0; i < 8; i++) chk("rstmid_all", 3'(i), 16'h0);
        @(negedge clk) reset = 1'b0;
        do_write(3'd7, 16'h0042);
        for (int i = 0; i < 8; i++) chk("rstmid_w7", 3'(i), (i == 7) ? 16'h0042 : 16'h0);

        // Random traffic against the array model; each read is taken before
        // the edge so it must show the pre-write value.
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  a;
            logic [15:0] d;
            logic        ld;
            @(negedge clk);
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            ld = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1; load = ld; din = d;
                clear_model();
                chk("rand_reset", a, 16'h0);
                @(posedge clk);
                #1 load = 1'b0;
                @(negedge clk) reset = 1'b0;
            end else begin
                din = d; load = ld;
                chk("rand_read", a, model[a]);
                @(posedge clk);
                if (ld) model[a] = d;
                #1 load = 1'b0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk("rand_final", 3'(i), model[i]);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 20 && sb.size() > 0; t++) #1;
        if (sb.size() > 0) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
